// File: rtl/seq_multiply.sv
// Sequential signed fixed-point multiplier.
// Multiplies operand magnitudes with one shift-add step per cycle, applies the sign,
// then produces the full product plus a saturated rescale to the operand format.
// Optional feature: define SEQ_MULTIPLY_ROUND_EN to round half up before rescaling
// (otherwise the rescale truncates toward minus infinity).
module seq_multiply #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     result_q,
    output logic                 sat
);

    localparam int CntW = $clog2(WIDTH + 1);

    // Rescale bounds, sign-extended to the widened product width.
    localparam logic signed [2*WIDTH:0] MaxQ = {{(WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [2*WIDTH:0] MinQ = {{(WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};
`ifdef SEQ_MULTIPLY_ROUND_EN
    localparam logic [2*WIDTH:0] RoundK = {{(2*WIDTH){1'b0}}, 1'b1} << (FRAC_BITS - 1);
`endif

    typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 sign_q, sign_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     resq_q, resq_d;
    logic                 sat_q, sat_d;
    logic                 done_q, done_d;

    logic [2*WIDTH-1:0]   prod_s;
    logic signed [2*WIDTH:0] prod_ext;
    logic signed [2*WIDTH:0] rounded;
    logic signed [2*WIDTH:0] shifted;
    logic [WIDTH-1:0]     resq_c;
    logic                 sat_c;

    // Two's complement magnitude; the most-negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Sign application, optional rounding, rescale and saturation of the magnitude product.
    always_comb begin
        prod_s   = sign_q ? -acc_q : acc_q;
        prod_ext = {prod_s[2*WIDTH-1], prod_s};
`ifdef SEQ_MULTIPLY_ROUND_EN
        rounded  = prod_ext + RoundK;
`else
        rounded  = prod_ext;
`endif
        shifted  = rounded >>> FRAC_BITS;
        sat_c    = 1'b0;
        resq_c   = shifted[WIDTH-1:0];
        if (shifted > MaxQ) begin
            sat_c  = 1'b1;
            resq_c = {1'b0, {(WIDTH - 1){1'b1}}};
        end else if (shifted < MinQ) begin
            sat_c  = 1'b1;
            resq_c = {1'b1, {(WIDTH - 1){1'b0}}};
        end
    end

    // Next-state and datapath updates for each FSM state.
    always_comb begin
        state_d  = state_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        resq_d   = resq_q;
        sat_d    = sat_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mplier_d = mag(multiplier);
                    mcand_d  = {{WIDTH{1'b0}}, mag(multiplicand)};
                    sign_d   = multiplier[WIDTH-1] ^ multiplicand[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StSign;
                end
            end
            StSign: begin
                prod_d  = prod_s;
                resq_d  = resq_c;
                sat_d   = sat_c;
                state_d = StDone;
            end
            StDone: begin
                // done is registered, so it is visible for the cycle after DONE.
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            resq_q   <= '0;
            sat_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            resq_q   <= resq_d;
            sat_q    <= sat_d;
            done_q   <= done_d;
        end
    end

    assign ready    = (state_q == StIdle);
    assign done     = done_q;
    assign result   = prod_q;
    assign result_q = resq_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_seq_multiply.sv
// Testbench for seq_multiply at WIDTH=16, FRAC_BITS=15.
module tb_seq_multiply;

    localparam int W = 16;
    localparam int F = 15;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a     = '0;
    logic [W-1:0]   b     = '0;
    logic           ready;
    logic           done;
    logic [2*W-1:0] result;
    logic [W-1:0]   result_q;
    logic           sat;

    seq_multiply #(.WIDTH(W), .FRAC_BITS(F)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplier   (a),
        .multiplicand (b),
        .ready        (ready),
        .done         (done),
        .result       (result),
        .result_q     (result_q),
        .sat          (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] res;
        logic [W-1:0]   q;
        logic           s;
    } exp_t;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        logic [W-1:0]   q_tr;
        logic [W-1:0]   q_rn;
        logic           s;
    } vec_t;

    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Independent reference using 64-bit integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint p;
        longint s;
        p = longint'($signed(x)) * longint'($signed(y));
`ifdef SEQ_MULTIPLY_ROUND_EN
        s = (p + (longint'(1) << (F - 1))) >>> F;
`else
        s = p >>> F;
`endif
        e.res = p[2*W-1:0];
        e.s   = 1'b0;
        if (s > 32767) begin
            e.q = 16'h7FFF;
            e.s = 1'b1;
        end else if (s < -32768) begin
            e.q = 16'h8000;
            e.s = 1'b1;
        end else begin
            e.q = s[W-1:0];
        end
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_e = sb.pop_front();
                check("result", 64'(result), 64'(mon_e.res));
                check("result_q", 64'(result_q), 64'(mon_e.q));
                check("sat", 64'(sat), 64'(mon_e.s));
            end
        end
    end

    task automatic wait_ready();
        for (int k = 0; k < 50; k++) begin
            if (ready) return;
            @(posedge clk);
            #1;
        end
        check("ready_timeout", 64'(ready), 64'd1);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e,
                         input bit glitch);
        int lat;
        int pre;
        lat = 0;
        wait_ready();
        pre = done_cnt;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~x;
        b     = ~y;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) check("ready_low_busy", 64'(ready), 64'd0);
            if (glitch && k == 5) begin
                start = 1'b1;
                a     = 16'h7FFF;
                b     = 16'h7FFF;
            end else if (glitch && k == 6) begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'd18);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("done_count", 64'(done_cnt - pre), 64'd1);
    endtask

    vec_t vecs[11];
    exp_t e;
    int   dcyc[3];
    int   pre;

    initial begin
        vecs[0]  = '{16'h4000, 16'h4000, 32'h1000_0000, 16'h2000, 16'h2000, 1'b0};
        vecs[1]  = '{16'h8000, 16'h8000, 32'h4000_0000, 16'h7FFF, 16'h7FFF, 1'b1};
        vecs[2]  = '{16'h8000, 16'h7FFF, 32'hC000_8000, 16'h8001, 16'h8001, 1'b0};
        vecs[3]  = '{16'hFFFD, 16'h0005, 32'hFFFF_FFF1, 16'hFFFF, 16'h0000, 1'b0};
        vecs[4]  = '{16'h0000, 16'h1234, 32'h0000_0000, 16'h0000, 16'h0000, 1'b0};
        vecs[5]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 16'h7FFE, 16'h7FFE, 1'b0};
        vecs[6]  = '{16'h8000, 16'h0001, 32'hFFFF_8000, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 32'h0000_0001, 16'h0000, 16'h0000, 1'b0};
        vecs[8]  = '{16'h8000, 16'hFFFF, 32'h0000_8000, 16'h0001, 16'h0001, 1'b0};
        vecs[9]  = '{16'h7FFF, 16'h8001, 32'hC000_FFFF, 16'h8001, 16'h8002, 1'b0};
        vecs[10] = '{16'h4000, 16'h0001, 32'h0000_4000, 16'h0000, 16'h0001, 1'b0};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_result_q", 64'(result_q), 64'd0);
        check("rst_sat", 64'(sat), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        foreach (vecs[i]) begin
            e.res = vecs[i].res;
            e.s   = vecs[i].s;
`ifdef SEQ_MULTIPLY_ROUND_EN
            e.q   = vecs[i].q_rn;
`else
            e.q   = vecs[i].q_tr;
`endif
            do_op(vecs[i].a, vecs[i].b, e, 1'b0);
        end

        // Outputs hold while idle
        repeat (5) @(posedge clk);
        #1;
        check("hold_result", 64'(result), 64'h0000_4000);

        // Second start mid-CALC is ignored
        do_op(16'h1234, 16'hF00D, model(16'h1234, 16'hF00D), 1'b1);

        // Reset mid-CALC aborts with no done pulse
        wait_ready();
        @(negedge clk);
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_result", 64'(result), 64'd0);
        check("abort_result_q", 64'(result_q), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        pre = done_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - pre), 64'd0);
        do_op(16'h1234, 16'h5678, model(16'h1234, 16'h5678), 1'b0);

        // Random operands
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = W'($urandom);
            y = W'($urandom);
            do_op(x, y, model(x, y), 1'b0);
        end

        // Start held high: back-to-back operations
        wait_ready();
        for (int i = 0; i < 3; i++) sb.push_back(model(16'hC001, 16'h2345));
        @(negedge clk);
        a     = 16'hC001;
        b     = 16'h2345;
        start = 1'b1;
        begin
            int n;
            n = 0;
            for (int k = 0; k < 100 && n < 3; k++) begin
                @(negedge clk);
                if (done) begin
                    dcyc[n] = cyc;
                    n++;
                    if (n == 3) start = 1'b0;
                end
            end
            check("held_pulses", 64'(n), 64'd3);
            if (n == 3) begin
                check("held_period_0", 64'(dcyc[1] - dcyc[0]), 64'd19);
                check("held_period_1", 64'(dcyc[2] - dcyc[1]), 64'd19);
            end
        end
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
